fifo_tile_reader: RTL

FIFO_TILE_READER -- requirements
Module: fifo_tile_reader

---
 rtl/fifo_tile_reader.sv | 77 +++++++
 1 files changed

// File: rtl/fifo_tile_reader.sv
// fifo_tile_reader: pops one TILE_LEN-word tile from an upstream FIFO into a 2-entry ready/valid output buffer.
// Optional FIFO_TILE_READER_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module fifo_tile_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef FIFO_TILE_READER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);
  localparam logic [7:0] TL = 8'(TILE_LEN);
  localparam logic [7:0] TL1 = 8'(TILE_LEN - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [7:0] issued, sent;
  logic [1:0] occ, occ_p;
  logic inflight, pop;
  logic [DATA_WIDTH-1:0] tail;
  assign out_valid = occ != 2'd0;
  assign pop = out_valid & out_ready;
  assign occ_p = occ - {1'b0, pop};
  assign busy = state != IDLE;
  assign out_last = out_valid && sent == TL1;
  // Words already buffered plus the one in flight must leave room for the next capture.
  assign fifo_rd_en = reset && state == RUN && !fifo_empty && issued < TL &&
                      ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      issued <= '0;
      sent <= '0;
      occ <= '0;
      inflight <= 1'b0;
      out_data <= '0;
      tail <= '0;
      done <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      occ <= occ_p + {1'b0, inflight};
      out_data <= (inflight && occ_p == 2'd0) ? fifo_data : pop ? tail : out_data;
      tail <= (inflight && occ_p == 2'd1) ? fifo_data : tail;
      done <= state == DRAIN && pop && out_last;
      if (state == IDLE) begin
        if (start && !done) begin
          state <= RUN;
          issued <= '0;
          sent <= '0;
        end
      end else begin
        issued <= issued + {7'b0, fifo_rd_en};
        sent <= sent + {7'b0, pop};
      end
      if (state == RUN && fifo_rd_en && issued == TL1) state <= DRAIN;
      if (state == DRAIN && pop && out_last) state <= IDLE;
    end
  end
`ifdef FIFO_TILE_READER_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) underrun_cnt <= '0;
    else if (state == RUN && issued < TL && fifo_empty && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif
endmodule
